// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the memory-stage controller states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memctl_state_t;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Free-running up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-access controller: holds one load/store request on the cache
// port until dhit, captures load data and stalls the pipeline meanwhile.
module mem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ren_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_i,
  input  logic              halt_i,
  input  logic              flush,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] load_o,
  output logic              mem_stall,
  output logic              done_o,
  output logic              halt_o,
  output logic [CNT_W-1:0]  wait_cnt
);

  memctl_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              req_ren_q, req_ren_d;
  logic              req_wen_q, req_wen_d;
  logic              halt_q, halt_d;

  logic access;
  logic in_req;

  assign access = (ren_i | wen_i) & ~flush & ~halt_q;
  assign in_req = (state_q == REQ);

  // A simultaneous ren/wen is latched as a store only; flush only matters before launch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    load_d    = load_q;
    req_ren_d = req_ren_q;
    req_wen_d = req_wen_q;
    halt_d    = halt_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          addr_d    = addr_i;
          store_d   = store_i;
          req_wen_d = wen_i;
          req_ren_d = ren_i & ~wen_i;
          state_d   = REQ;
        end else if (halt_i && !flush) begin
          halt_d = 1'b1;
        end
      end
      REQ: begin
        if (dhit) begin
          if (req_ren_q) begin
            load_d = dmemload;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      store_q   <= '0;
      load_q    <= '0;
      req_ren_q <= 1'b0;
      req_wen_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      load_q    <= load_d;
      req_ren_q <= req_ren_d;
      req_wen_q <= req_wen_d;
      halt_q    <= halt_d;
    end
  end

  // Stall through the whole REQ window so the latches only move on the DONE edge,
  // when load_o already holds the returned data.
  assign mem_stall = in_req | ((state_q == IDLE) & access);
  assign dmemREN   = in_req & req_ren_q;
  assign dmemWEN   = in_req & req_wen_q;
  assign dmemaddr  = addr_q;
  assign dmemstore = store_q;
  assign load_o    = load_q;
  assign done_o    = (state_q == DONE);
  assign halt_o    = halt_q;

  sat_counter #(
    .W(CNT_W)
  ) u_wait_cnt (
    .clk    (CLK),
    .rst_n  (nRST),
    .inc_i  (in_req & ~dhit),
    .count_o(wait_cnt)
  );

endmodule
